// File: rtl/stream_splitter_pkg.sv
// Shared definitions for the stream splitter: burst-mode selectors,
// statistics counter width and the joint input-ready helper.
package stream_splitter_pkg;

    localparam string BURST_YES = "yes";
    localparam string BURST_NO  = "no";
    localparam int    CNT_W     = 16;

    // Input-side ready for two output slots.
    // With burst enabled, a slot that is draining this cycle counts as free.
    // Without burst, only register state is consulted.
    function automatic logic joint_ready(
        input logic burst_en,
        input logic free0,
        input logic free1,
        input logic valid0,
        input logic valid1
    );
        logic ready_s;
        if (burst_en) begin
            ready_s = free0 && free1;
        end else begin
            ready_s = !valid0 && !valid1;
        end
        return ready_s;
    endfunction

endpackage

// File: rtl/stream_slot.sv
// Single-entry output slot: one valid bit plus one data register.
// A load always wins over a drain in the same cycle, so a slot that is
// both handing off and being refilled stays valid with the new data.
module stream_slot #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] din,
    input  logic         ready,
    output logic         valid,
    output logic [W-1:0] data,
    output logic         free
);

    logic         valid_r;
    logic [W-1:0] data_r;

    // Slot state: reset clears, load fills, handshake empties, else hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r <= 1'b0;
            data_r  <= '0;
        end else if (load) begin
            valid_r <= 1'b1;
            data_r  <= din;
        end else if (valid_r && ready) begin
            valid_r <= 1'b0;
            data_r  <= data_r;
        end else begin
            valid_r <= valid_r;
            data_r  <= data_r;
        end
    end

    assign valid = valid_r;
    assign data  = data_r;
    assign free  = !valid_r || ready;

endmodule

// File: rtl/stream_splitter.sv
// Stream splitter: one valid/ready input word of WIDTH0+WIDTH1 bits fans out
// into two independently handshaken output streams, each held in its own slot.
// A new word is taken only once both halves of the previous word are gone
// (or leaving this cycle when BURST is "yes").
// Optional build macro STREAM_SPLITTER_STATS_EN adds oCount_AM, a wrapping
// count of accepted input words.
module stream_splitter
    import stream_splitter_pkg::*;
#(
    parameter int    WIDTH0 = 4,
    parameter int    WIDTH1 = 4,
    parameter string BURST  = BURST_YES
) (
    input  logic                     iCLK,
    input  logic                     iRST,
    input  logic                     iValid_AM,
    output logic                     oReady_AM,
    input  logic [WIDTH0+WIDTH1-1:0] iData_AM,
    output logic                     oValid_BM0,
    input  logic                     iReady_BM0,
    output logic [WIDTH0-1:0]        oData_BM0,
    output logic                     oValid_BM1,
    input  logic                     iReady_BM1,
    output logic [WIDTH1-1:0]        oData_BM1
`ifdef STREAM_SPLITTER_STATS_EN
    ,
    output logic [CNT_W-1:0]         oCount_AM
`endif
);

    // Anything other than "no" runs at full throughput.
    localparam logic BURST_EN = (BURST != BURST_NO);

    logic free0_s;
    logic free1_s;
    logic ready_s;
    logic accept_s;

    stream_slot #(.W(WIDTH0)) u_slot0 (
        .clk   (iCLK),
        .rst   (iRST),
        .load  (accept_s),
        .din   (iData_AM[WIDTH0-1:0]),
        .ready (iReady_BM0),
        .valid (oValid_BM0),
        .data  (oData_BM0),
        .free  (free0_s)
    );

    stream_slot #(.W(WIDTH1)) u_slot1 (
        .clk   (iCLK),
        .rst   (iRST),
        .load  (accept_s),
        .din   (iData_AM[WIDTH0+WIDTH1-1:WIDTH0]),
        .ready (iReady_BM1),
        .valid (oValid_BM1),
        .data  (oData_BM1),
        .free  (free1_s)
    );

    // Joint ready: both slots must be able to take a new half; never ready in reset.
    always_comb begin
        ready_s = joint_ready(BURST_EN, free0_s, free1_s, oValid_BM0, oValid_BM1);
        if (iRST) begin
            oReady_AM = 1'b0;
        end else begin
            oReady_AM = ready_s;
        end
        accept_s = iValid_AM && oReady_AM;
    end

`ifdef STREAM_SPLITTER_STATS_EN
    logic [CNT_W-1:0] count_r;

    // Accepted-word counter; wraps from all-ones back to zero.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            count_r <= '0;
        end else if (accept_s) begin
            count_r <= count_r + CNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign oCount_AM = count_r;
`else
    // Statistics disabled: no counter state and no count port.
`endif

endmodule

// File: tb/tb_stream_splitter.sv
// Self-checking bench for stream_splitter. Two instances are exercised:
// index 0 built with BURST="yes", index 1 with BURST="no". Expected halves are
// queued when a word is issued; a negedge monitor pops and compares on every
// output handshake.
module tb_stream_splitter;

    logic       clk;
    logic       rst;
    logic       vin    [2];
    logic [7:0] din    [2];
    logic       rdy_in [2];
    logic       vout   [4];
    logic       rin    [4];
    logic [3:0] dout   [4];
`ifdef STREAM_SPLITTER_STATS_EN
    logic [15:0] cnt   [2];
`endif

    logic [3:0] exp_q [4][$];
    int  checks;
    int  errors;
    bit  mon_en;

    stream_splitter #(.WIDTH0(4), .WIDTH1(4), .BURST("yes")) dut_y (
        .iCLK       (clk),
        .iRST       (rst),
        .iValid_AM  (vin[0]),
        .oReady_AM  (rdy_in[0]),
        .iData_AM   (din[0]),
        .oValid_BM0 (vout[0]),
        .iReady_BM0 (rin[0]),
        .oData_BM0  (dout[0]),
        .oValid_BM1 (vout[1]),
        .iReady_BM1 (rin[1]),
        .oData_BM1  (dout[1])
`ifdef STREAM_SPLITTER_STATS_EN
        ,
        .oCount_AM  (cnt[0])
`endif
    );

    stream_splitter #(.WIDTH0(4), .WIDTH1(4), .BURST("no")) dut_n (
        .iCLK       (clk),
        .iRST       (rst),
        .iValid_AM  (vin[1]),
        .oReady_AM  (rdy_in[1]),
        .iData_AM   (din[1]),
        .oValid_BM0 (vout[2]),
        .iReady_BM0 (rin[2]),
        .oData_BM0  (dout[2]),
        .oValid_BM1 (vout[3]),
        .iReady_BM1 (rin[3]),
        .oData_BM1  (dout[3])
`ifdef STREAM_SPLITTER_STATS_EN
        ,
        .oCount_AM  (cnt[1])
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
        end
    endtask

    // Monitor: every completed output handshake must match the oldest expectation.
    always @(negedge clk) begin
        logic [3:0] e;
        if (mon_en && !rst) begin
            for (int c = 0; c < 4; c++) begin
                if (vout[c] && rin[c]) begin
                    checks++;
                    if (exp_q[c].size() == 0) begin
                        errors++;
                        $display("FAIL mon_extra ch%0d actual=%h required=none t=%0t", c, dout[c], $time);
                    end else begin
                        e = exp_q[c].pop_front();
                        if (dout[c] !== e) begin
                            errors++;
                            $display("FAIL mon_data ch%0d actual=%h required=%h t=%0t", c, dout[c], e, $time);
                        end
                    end
                end
            end
        end
    end

    // Issue one word to instance d; waits (bounded) for acceptance.
    task automatic send(input int d, input logic [7:0] w, output int cyc);
        bit acc;
        acc = 1'b0;
        cyc = 0;
        exp_q[2*d].push_back(w[3:0]);
        exp_q[2*d+1].push_back(w[7:4]);
        vin[d] = 1'b1;
        din[d] = w;
        while (!acc && cyc < 20) begin
            @(negedge clk);
            acc = rdy_in[d];
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("send_accept", {15'd0, acc}, 16'd1);
        vin[d] = 1'b0;
    endtask

    task automatic set_readies(input logic r);
        for (int c = 0; c < 4; c++) rin[c] = r;
    endtask

    initial begin
        int cyc;
        int tot;
        checks = 0;
        errors = 0;
        mon_en = 1'b1;
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            vin[d] = 1'b0;
            din[d] = 8'h00;
        end
        set_readies(1'b1);

        // Reset state: cleared outputs, input not ready even with readies high.
        @(posedge clk); #1;
        repeat (2) begin
            @(negedge clk);
            for (int c = 0; c < 4; c++) begin
                chk("rst_valid", {15'd0, vout[c]}, 16'd0);
                chk("rst_data", {12'd0, dout[c]}, 16'd0);
            end
            chk("rst_ready_y", {15'd0, rdy_in[0]}, 16'd0);
            chk("rst_ready_n", {15'd0, rdy_in[1]}, 16'd0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("idle_ready_y", {15'd0, rdy_in[0]}, 16'd1);
        chk("idle_ready_n", {15'd0, rdy_in[1]}, 16'd1);
        @(posedge clk); #1;

        // Basic: both settings, valid for exactly one cycle.
        for (int d = 0; d < 2; d++) begin
            send(d, 8'hba, cyc);
            @(negedge clk);
            chk("basic_v0", {15'd0, vout[2*d]}, 16'd1);
            chk("basic_v1", {15'd0, vout[2*d+1]}, 16'd1);
            @(posedge clk); #1;
            @(negedge clk);
            chk("basic_v0_gone", {15'd0, vout[2*d]}, 16'd0);
            chk("basic_v1_gone", {15'd0, vout[2*d+1]}, 16'd0);
            @(posedge clk); #1;
        end

        // Skew on the burst instance: stream 1 stalls, stream 0 drains.
        rin[1] = 1'b0;
        send(0, 8'h87, cyc);
        vin[0] = 1'b1;
        din[0] = 8'h42;
        repeat (3) begin
            @(negedge clk);
            chk("skew_ready", {15'd0, rdy_in[0]}, 16'd0);
            chk("skew_v1", {15'd0, vout[1]}, 16'd1);
            chk("skew_d1", {12'd0, dout[1]}, 16'h0008);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("skew_v0_drained", {15'd0, vout[0]}, 16'd0);
        @(posedge clk); #1;
        vin[0] = 1'b0;
        rin[1] = 1'b1;
        @(negedge clk);
        chk("skew_ready_back", {15'd0, rdy_in[0]}, 16'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("skew_v1_drained", {15'd0, vout[1]}, 16'd0);
        @(posedge clk); #1;

        // Throughput: 8 words back-to-back into each instance.
        for (int d = 0; d < 2; d++) begin
            tot = 0;
            for (int i = 0; i < 8; i++) begin
                send(d, 8'h10 + 8'(i), cyc);
                tot += cyc;
            end
            chk(d == 0 ? "thru_cycles_y" : "thru_cycles_n", 16'(tot), d == 0 ? 16'd8 : 16'd15);
            repeat (3) @(posedge clk);
            #1;
        end

        // Backpressure on the burst instance: both outputs stalled.
        set_readies(1'b0);
        send(0, 8'h5c, cyc);
        exp_q[0].push_back(4'hd);
        exp_q[1].push_back(4'h3);
        vin[0] = 1'b1;
        din[0] = 8'h3d;
        repeat (3) begin
            @(negedge clk);
            chk("bp_ready", {15'd0, rdy_in[0]}, 16'd0);
            chk("bp_d0", {12'd0, dout[0]}, 16'h000c);
            chk("bp_d1", {12'd0, dout[1]}, 16'h0005);
            @(posedge clk); #1;
        end
        set_readies(1'b1);
        @(negedge clk);
        chk("bp_ready_release", {15'd0, rdy_in[0]}, 16'd1);
        @(posedge clk); #1;
        vin[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset mid-word: stream 1 holds its half when reset hits.
        rin[1] = 1'b0;
        send(0, 8'h96, cyc);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_ready_y", {15'd0, rdy_in[0]}, 16'd0);
        chk("midrst_ready_n", {15'd0, rdy_in[1]}, 16'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q[0].delete();
        exp_q[1].delete();
        rin[1] = 1'b1;
        @(negedge clk);
        chk("midrst_v0", {15'd0, vout[0]}, 16'd0);
        chk("midrst_v1", {15'd0, vout[1]}, 16'd0);
        chk("midrst_d0", {12'd0, dout[0]}, 16'd0);
        chk("midrst_d1", {12'd0, dout[1]}, 16'd0);
        chk("midrst_ready_after", {15'd0, rdy_in[0]}, 16'd1);
        @(posedge clk); #1;
        send(0, 8'he1, cyc);
        repeat (3) @(posedge clk);
        #1;

        for (int c = 0; c < 4; c++) chk("queue_drained", 16'(exp_q[c].size()), 16'd0);

`ifdef STREAM_SPLITTER_STATS_EN
        chk("count_y", cnt[0], 16'd1);
        chk("count_n", cnt[1], 16'd0);
        mon_en = 1'b0;
        vin[0] = 1'b1;
        din[0] = 8'h00;
        repeat (65534) @(posedge clk);
        #1;
        chk("count_max", cnt[0], 16'hffff);
        @(posedge clk); #1;
        vin[0] = 1'b0;
        chk("count_wrap", cnt[0], 16'h0000);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
